// File: rtl/lsu.sv
// Load/store unit: one data-memory access at a time over a valid/ready
// request bus with an unhandshaked response. Handles byte-lane alignment,
// write strobes and load sign/zero extension.
// Build option: LSU_MISALIGN_CHECK_EN faults size-misaligned accesses
// without touching the bus.
// XLEN defaults to 64 when the macro is not supplied.

`ifndef XLEN
`define XLEN 64
`endif

// state | meaning
// IDLE  | ready for a new access
// REQ   | bus request presented, waiting for mem_req_ready
// WAIT  | request accepted, waiting for response or timeout
// DONE  | result presented, waiting for out_ready

module lsu #(
   parameter int TIMEOUT = 1023
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [`XLEN-1:0]    in_addr,
   input  logic [`XLEN-1:0]    in_wdata,
   input  logic [3:0]          in_op,
   input  logic [4:0]          in_rd,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [`XLEN-1:0]    out_rdata,
   output logic [4:0]          out_rd,
   output logic                out_err,
   output logic                mem_req_valid,
   input  logic                mem_req_ready,
   output logic [`XLEN-1:0]    mem_req_addr,
   output logic                mem_req_we,
   output logic [`XLEN-1:0]    mem_req_wdata,
   output logic [`XLEN/8-1:0]  mem_req_wstrb,
   input  logic                mem_rsp_valid,
   input  logic [`XLEN-1:0]    mem_rsp_rdata,
   input  logic                mem_rsp_err
);

   localparam int XLEN = `XLEN;
   localparam int SW   = XLEN / 8;
   localparam int CW   = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

   state_t          state, state_nxt;
   logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
   logic [3:0]      op_q;
   logic [4:0]      rd_q;
   logic [SW-1:0]   wstrb_q;
   logic            err_q;
   logic [CW-1:0]   tmr_q;
   logic [2:0]      lane;
   logic [2*SW-1:0] strb_base, strb_wide;
   logic            misalign;
   logic            tmr_tc;

   assign lane   = in_addr[2:0];
   assign tmr_tc = (tmr_q == '0);

   // Load path: shift the addressed lane down (bytes past the doubleword
   // fall in as zero) then extend to XLEN.
   function automatic logic [XLEN-1:0] ext_load(input logic [XLEN-1:0] raw,
                                                input logic [2:0]      ln,
                                                input logic [3:0]      op);
      logic [XLEN-1:0] sh;
      sh = raw >> {ln, 3'b000};
      case (op[1:0])
         2'b00:   ext_load = op[2] ? {{(XLEN-8){1'b0}}, sh[7:0]}
                                   : {{(XLEN-8){sh[7]}}, sh[7:0]};
         2'b01:   ext_load = op[2] ? {{(XLEN-16){1'b0}}, sh[15:0]}
                                   : {{(XLEN-16){sh[15]}}, sh[15:0]};
         2'b10:   ext_load = op[2] ? {{(XLEN-32){1'b0}}, sh[31:0]}
                                   : {{(XLEN-32){sh[31]}}, sh[31:0]};
         default: ext_load = sh;
      endcase
   endfunction

   // Store strobe: size mask shifted to the lane; upper half is dropped.
   always_comb begin
      strb_base = '0;
      case (in_op[1:0])
         2'b00:   strb_base = (2*SW)'(8'h01);
         2'b01:   strb_base = (2*SW)'(8'h03);
         2'b10:   strb_base = (2*SW)'(8'h0F);
         default: strb_base = (2*SW)'(8'hFF);
      endcase
      strb_wide = strb_base << lane;
   end

`ifdef LSU_MISALIGN_CHECK_EN
   // Natural-alignment check against the access size.
   always_comb begin
      case (in_op[1:0])
         2'b01:   misalign = in_addr[0];
         2'b10:   misalign = |in_addr[1:0];
         2'b11:   misalign = |in_addr[2:0];
         default: misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake outputs.
   always_comb begin
      state_nxt     = state;
      in_ready      = 1'b0;
      mem_req_valid = 1'b0;
      out_valid     = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_nxt = misalign ? S_DONE : S_REQ;
         end
         S_REQ: begin
            mem_req_valid = 1'b1;
            if (mem_req_ready) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (mem_rsp_valid || tmr_tc) state_nxt = S_DONE;
         end
         S_DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_nxt = S_IDLE;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Access capture, timeout down-counter and result capture.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         wstrb_q <= '0;
         err_q   <= 1'b0;
         tmr_q   <= '0;
      end else begin
         case (state)
            S_IDLE: if (in_valid) begin
               addr_q  <= in_addr;
               op_q    <= in_op;
               rd_q    <= in_rd;
               wdata_q <= in_wdata << {lane, 3'b000};
               wstrb_q <= in_op[3] ? strb_wide[SW-1:0] : '0;
               rdata_q <= '0;
               err_q   <= misalign;
            end
            S_REQ: if (mem_req_ready) tmr_q <= CW'(TIMEOUT - 1);
            S_WAIT: begin
               // A response in the terminal-count cycle still wins.
               if (mem_rsp_valid) begin
                  err_q   <= mem_rsp_err;
                  rdata_q <= (mem_rsp_err || op_q[3]) ? '0
                             : ext_load(mem_rsp_rdata, addr_q[2:0], op_q);
               end else if (tmr_tc) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end else begin
                  tmr_q <= tmr_q - 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign mem_req_addr  = {addr_q[XLEN-1:3], 3'b000};
   assign mem_req_we    = (state == S_REQ) && op_q[3];
   assign mem_req_wdata = wdata_q;
   assign mem_req_wstrb = wstrb_q;
   assign out_rdata     = rdata_q;
   assign out_rd        = rd_q;
   assign out_err       = err_q;

endmodule

// File: tb/tb_lsu.sv
// Bench for lsu: directed test-plan accesses with literal expectations plus
// randomized accesses, all checked every cycle against a byte-level model.

`timescale 1ns/1ps

module tb_lsu;
   localparam int TO = 1023;

   logic        clk = 1'b0, rst_n = 1'b0;
   logic        in_valid = 1'b0, in_ready;
   logic [63:0] in_addr = '0, in_wdata = '0;
   logic [3:0]  in_op = '0;
   logic [4:0]  in_rd = '0;
   logic        out_valid, out_ready = 1'b0, out_err;
   logic [63:0] out_rdata;
   logic [4:0]  out_rd;
   logic        mem_req_valid, mem_req_ready = 1'b0, mem_req_we;
   logic [63:0] mem_req_addr, mem_req_wdata;
   logic [7:0]  mem_req_wstrb;
   logic        mem_rsp_valid = 1'b0, mem_rsp_err = 1'b0;
   logic [63:0] mem_rsp_rdata = '0;

   always #5 clk = ~clk;

   lsu dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
      .in_wdata(in_wdata), .in_op(in_op), .in_rd(in_rd),
      .out_valid(out_valid), .out_ready(out_ready), .out_rdata(out_rdata),
      .out_rd(out_rd), .out_err(out_err),
      .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
      .mem_req_addr(mem_req_addr), .mem_req_we(mem_req_we),
      .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
      .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
      .mem_rsp_err(mem_rsp_err)
   );

   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   typedef struct {
      logic [63:0] raddr, rwdata, rdata;
      logic [7:0]  wstrb;
      logic        we, err, bus;
      logic [4:0]  rd;
   } exp_t;

   exp_t cur;
   bit   have_cur = 0;

   // Expected outcome of one access, built byte by byte from the access rules.
   function automatic exp_t model(input logic [63:0] a, input logic [63:0] wd,
                                  input logic [3:0] op, input logic [4:0] rd,
                                  input logic [63:0] rdat, input bit rerr, input bit tmo);
      exp_t        e;
      int          ln, n;
      logic [63:0] v;
      bit          mis;
      ln  = int'(a[2:0]);
      n   = 1 << op[1:0];
      v   = '0;
      mis = 0;
`ifdef LSU_MISALIGN_CHECK_EN
      mis = (ln % n) != 0;
`endif
      e.raddr  = a & ~64'h7;
      e.we     = op[3];
      e.rd     = rd;
      e.bus    = !mis;
      e.rwdata = wd << (8 * ln);
      e.wstrb  = '0;
      if (op[3])
         for (int i = 0; i < n; i++) if (ln + i < 8) e.wstrb[ln+i] = 1'b1;
      e.err   = mis || rerr || tmo;
      e.rdata = '0;
      if (!op[3] && !e.err) begin
         for (int i = 0; i < n; i++)
            if (ln + i < 8) v[8*i +: 8] = rdat[8*(ln+i) +: 8];
         if (!op[2] && n < 8 && v[8*n-1])
            for (int i = 8 * n; i < 64; i++) v[i] = 1'b1;
         e.rdata = v;
      end
      return e;
   endfunction

   // Every-cycle compare of bus request and result against the current expectation.
   always @(negedge clk) begin
      if (rst_n) begin
         if (mem_req_valid) begin
            if (!have_cur) chk("unexpected_req", 1, 0);
            else if (!cur.bus) chk("req_on_misaligned", 1, 0);
            else begin
               chk("req_addr", mem_req_addr, cur.raddr);
               chk("req_we", mem_req_we, cur.we);
               chk("req_wstrb", mem_req_wstrb, cur.wstrb);
               if (cur.we) chk("req_wdata", mem_req_wdata, cur.rwdata);
            end
         end
         if (out_valid) begin
            if (!have_cur) chk("unexpected_out_valid", 1, 0);
            else begin
               chk("out_rdata", out_rdata, cur.rdata);
               chk("out_err", out_err, cur.err);
               chk("out_rd", out_rd, cur.rd);
            end
         end
      end
   end

   // One complete access; memory-side timing chosen by the caller.
   task automatic access(input logic [63:0] a, input logic [63:0] wd, input logic [3:0] op,
                         input logic [4:0] rd, input logic [63:0] rdat, input bit rerr,
                         input int rdy_dly, input int rsp_dly, input bit no_rsp,
                         input int ord_dly,
                         output logic [63:0] got_rdata, output logic got_err,
                         output logic [63:0] got_addr, output logic [7:0] got_strb,
                         output logic [63:0] got_wdata, output int wait_cycles);
      int n;
      got_rdata = '0; got_err = 1'b0; got_addr = '0; got_strb = '0; got_wdata = '0;
      wait_cycles = 0;
      cur = model(a, wd, op, rd, rdat, rerr, no_rsp);
      n = 0;
      while (!in_ready && n < 50) begin step(); n++; end
      if (!in_ready) begin chk("in_ready_timeout", 0, 1); return; end
      have_cur = 1;
      in_valid = 1'b1; in_addr = a; in_wdata = wd; in_op = op; in_rd = rd;
      step();
      in_valid = 1'b0;
      chk("in_ready_busy", in_ready, 0);
      if (cur.bus) begin
         chk("req_latency", mem_req_valid, 1);
         n = 0;
         while (!mem_req_valid && n < 10) begin step(); n++; end
         if (!mem_req_valid) begin chk("req_timeout", 0, 1); have_cur = 0; return; end
         got_addr = mem_req_addr; got_strb = mem_req_wstrb; got_wdata = mem_req_wdata;
         for (int i = 0; i < rdy_dly; i++) begin
            // stray responses while the request is pending must be ignored
            mem_rsp_valid = (i == 0); mem_rsp_err = 1'b1; mem_rsp_rdata = '1;
            step();
         end
         mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0;
         mem_req_ready = 1'b1;
         step();
         mem_req_ready = 1'b0;
         if (no_rsp) begin
            n = 0;
            while (!out_valid && n < TO + 20) begin step(); n++; end
            wait_cycles = n;
         end else begin
            repeat (rsp_dly) step();
            chk("no_early_out_valid", out_valid, 0);
            mem_rsp_valid = 1'b1; mem_rsp_rdata = rdat; mem_rsp_err = rerr;
            step();
            mem_rsp_valid = 1'b0; mem_rsp_rdata = '0; mem_rsp_err = 1'b0;
            chk("rsp_to_out_latency", out_valid, 1);
         end
      end else begin
         chk("misalign_latency", out_valid, 1);
      end
      n = 0;
      while (!out_valid && n < TO + 20) begin step(); n++; end
      if (!out_valid) begin chk("out_valid_timeout", 0, 1); have_cur = 0; return; end
      got_rdata = out_rdata; got_err = out_err;
      repeat (ord_dly) step();
      chk("out_valid_held", out_valid, 1);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      have_cur = 0;
      chk("back_to_idle", in_ready, 1);
   endtask

   logic [63:0] g_rd, g_addr, g_wd, r_a, r_wd, r_rdat;
   logic [7:0]  g_st;
   logic        g_err, r_err;
   logic [3:0]  r_op;
   int          g_wc;

   initial begin
      // reset state
      repeat (3) step();
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_err", out_err, 0);
      chk("rst_req_valid", mem_req_valid, 0);
      chk("rst_req_we", mem_req_we, 0);
      chk("rst_out_rdata", out_rdata, 0);
      chk("rst_out_rd", out_rd, 0);
      chk("rst_req_addr", mem_req_addr, 0);
      chk("rst_req_wstrb", mem_req_wstrb, 0);
      chk("rst_req_wdata", mem_req_wdata, 0);
      rst_n = 1'b1;
      step();

      // LB / LBU sign and zero extension
      access(64'h8000_0003, 0, 4'b0000, 5'd1, 64'h0000_0000_8000_0000, 0, 0, 0, 0, 0,
             g_rd, g_err, g_addr, g_st, g_wd, g_wc);
      chk("lb_rdata", g_rd, 64'hFFFF_FFFF_FFFF_FF80);
      access(64'h8000_0003, 0, 4'b0100, 5'd2, 64'h0000_0000_8000_0000, 0, 0, 0, 0, 1,
             g_rd, g_err, g_addr, g_st, g_wd, g_wc);
      chk("lbu_rdata", g_rd, 64'h80);

      // SH lane 6
      access(64'h8000_0006, 64'h1234, 4'b1001, 5'd3, '0, 0, 0, 0, 0, 0,
             g_rd, g_err, g_addr, g_st, g_wd, g_wc);
      chk("sh_addr", g_addr, 64'h8000_0000);
      chk("sh_wstrb", g_st, 8'hC0);
      chk("sh_wdata", g_wd, 64'h1234_0000_0000_0000);
      chk("sh_rdata", g_rd, 0);

      // LD with stalled request, late response and held result
      access(64'h8000_0010, 0, 4'b0011, 5'd4, 64'hDEAD_BEEF_0123_4567, 0, 3, 5, 0, 3,
             g_rd, g_err, g_addr, g_st, g_wd, g_wc);
      chk("ld_rdata", g_rd, 64'hDEAD_BEEF_0123_4567);
      chk("ld_err", g_err, 0);

      // bus error
      access(64'h8000_0018, 0, 4'b0011, 5'd5, 64'h1111, 1, 0, 1, 0, 0,
             g_rd, g_err, g_addr, g_st, g_wd, g_wc);
      chk("berr_err", g_err, 1);
      chk("berr_rdata", g_rd, 0);

      // timeout
      access(64'h8000_0020, 0, 4'b0010, 5'd6, '0, 0, 0, 0, 1, 0,
             g_rd, g_err, g_addr, g_st, g_wd, g_wc);
      chk("timeout_cycles", g_wc, TO);
      chk("timeout_err", g_err, 1);
      chk("timeout_rdata", g_rd, 0);

      // misaligned / lane-truncated accesses
      access(64'h8000_0002, 0, 4'b0010, 5'd7, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 0,
             g_rd, g_err, g_addr, g_st, g_wd, g_wc);
`ifdef LSU_MISALIGN_CHECK_EN
      chk("lw_mis_err", g_err, 1);
      chk("lw_mis_rdata", g_rd, 0);
`else
      chk("lw_mis_err", g_err, 0);
      chk("lw_mis_rdata", g_rd, 64'h3344_5566);
`endif
      access(64'h8000_0006, 64'hAABB_CCDD, 4'b1010, 5'd8, '0, 0, 0, 0, 0, 0,
             g_rd, g_err, g_addr, g_st, g_wd, g_wc);
`ifdef LSU_MISALIGN_CHECK_EN
      chk("sw_trunc_err", g_err, 1);
`else
      chk("sw_trunc_wstrb", g_st, 8'hC0);
      chk("sw_trunc_wdata", g_wd, 64'hCCDD_0000_0000_0000);
      chk("sw_trunc_err", g_err, 0);
`endif
      access(64'h8000_0007, 0, 4'b0001, 5'd9, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 0,
             g_rd, g_err, g_addr, g_st, g_wd, g_wc);
`ifdef LSU_MISALIGN_CHECK_EN
      chk("lh_trunc_err", g_err, 1);
`else
      chk("lh_trunc_rdata", g_rd, 64'h80);
`endif

      // reset during WAIT, then a stray response
      cur = model(64'h8000_0040, 0, 4'b0011, 5'd10, '0, 0, 0);
      have_cur = 1;
      in_valid = 1'b1; in_addr = 64'h8000_0040; in_op = 4'b0011; in_rd = 5'd10;
      step();
      in_valid = 1'b0;
      mem_req_ready = 1'b1;
      step();
      mem_req_ready = 1'b0;
      step();
      have_cur = 0;
      rst_n = 1'b0;
      step();
      chk("midrst_in_ready", in_ready, 1);
      chk("midrst_req_valid", mem_req_valid, 0);
      rst_n = 1'b1;
      mem_rsp_valid = 1'b1; mem_rsp_rdata = 64'h55;
      step();
      mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
      for (int i = 0; i < 3; i++) begin
         chk("stray_out_valid", out_valid, 0);
         step();
      end

      // randomized accesses
      for (int t = 0; t < 60; t++) begin
         r_a    = {$urandom, $urandom};
         r_wd   = {$urandom, $urandom};
         r_rdat = {$urandom, $urandom};
         r_op   = 4'($urandom_range(0, 15));
         r_err  = ($urandom_range(0, 7) == 0);
         access(r_a, r_wd, r_op, 5'($urandom_range(0, 31)), r_rdat, r_err,
                $urandom_range(0, 3), $urandom_range(0, 3), 0, $urandom_range(0, 2),
                g_rd, g_err, g_addr, g_st, g_wd, g_wc);
      end

      repeat (2) step();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute run-time bound.
   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      errors++;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1);
   end
endmodule
